// File: rtl/muldiv_if.sv
// Request/response bundle between the EX-stage sequencer (master) and muldiv_unit (slave).
// The unit takes a start pulse only while busy is low, and it answers each accepted start with exactly one done pulse.
// The unit only samples op_a, op_b and funct3 in the start cycle. A flush cancels the operation in flight.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. It uses shift-add for multiply and restoring division for divide.
// Each operation runs one bit per cycle on operand magnitudes, with a final sign-fixup cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] dbg_state_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_q_q, neg_q_d;
    logic                neg_r_q, neg_r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rmd;

    // MULH, MULHSU, DIV and REM read rs1 as signed. Only MULH, DIV and REM also read rs2 as signed.
    assign a_sgn = bus.op_a[XLEN-1] &
                   ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110));
    assign b_sgn = bus.op_b[XLEN-1] &
                   ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110));
    assign abs_a = a_sgn ? (~bus.op_a + 1'b1) : bus.op_a;
    assign abs_b = b_sgn ? (~bus.op_b + 1'b1) : bus.op_b;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[XLEN];

    assign prod = neg_q_q ? (~acc_q + 1'b1) : acc_q;
    assign quo  = neg_q_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign rmd  = neg_r_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        b_d      = b_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d  = bus.funct3;
                    rem_d = '0;
                    cnt_d = '0;
                    // Multiply keeps the multiplier in the accumulator's low half. Divide keeps the dividend there.
                    acc_d = {{XLEN{1'b0}}, (bus.funct3[2] ? abs_a : abs_b)};
                    b_d   = bus.funct3[2] ? abs_b : abs_a;
                    // A zero divisor must leave the all-ones quotient unnegated.
                    neg_q_d = (a_sgn ^ b_sgn) & ~(bus.funct3[2] && (bus.op_b == '0));
                    neg_r_d = a_sgn;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (f3_q[2]) begin
                    rem_d = div_ge ? div_diff : div_shift;
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_SIGN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SIGN: begin
                if (f3_q[2]) begin
                    result_d = f3_q[1] ? rmd : quo;
                end else begin
                    result_d = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, abort/handshake sequences and a random regression against an RV32M model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    logic [31:0] last_res;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, ubs, sq;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = $signed(a);
        sb  = $signed(b);
        ubs = {32'b0, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ubs; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sq = sa / sb; p = sq; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = sa % sb; p = sq; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at posedge+1 of the launch cycle; returns at posedge+1 of the cycle after that.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
    endtask

    // k counts cycles after the launch cycle. If inj_k or fl_k is nonzero, a start (MUL 2x2) or a flush is driven in cycle k.
    task automatic wait_done(input int budget, input int inj_k, input int fl_k,
                             output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int k = 1; k <= budget; k++) begin
            bus.flush = (k == fl_k);
            if (k == inj_k) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'b000;
                bus.op_a   = 32'd2;
                bus.op_b   = 32'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.busy && !bus.done) busy_n++;
            if (bus.done && lat < 0) lat = k;
            @(posedge clk);
            #1;
            if (lat >= 0) begin
                bus.flush = 1'b0;
                bus.start = 1'b0;
                return;
            end
        end
        bus.flush = 1'b0;
        bus.start = 1'b0;
    endtask

    int          lat, busy_n;
    logic [31:0] exp_v;

    initial begin
        checks = 0;
        errors = 0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        rst = 1'b1;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].f3, vecs[i].a, vecs[i].b);
            wait_done(LAT + 10, 0, 0, lat, busy_n);
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(LAT - 1));
            last_res = vecs[i].exp;
        end

        // A start during busy is ignored. A start in the cycle right after DONE is accepted.
        launch(3'd5, 32'd9, 32'd3);
        wait_done(LAT + 10, 10, 0, lat, busy_n);
        chk("ignored_start_latency", 32'(lat), 32'(LAT));
        chk("ignored_start_result", bus.result, 32'd3);
        launch(3'd7, 32'd100, 32'd7);
        wait_done(LAT + 10, 0, 0, lat, busy_n);
        chk("b2b_latency", 32'(lat), 32'(LAT));
        chk("b2b_result", bus.result, 32'd2);
        last_res = 32'd2;

        // Flush mid-operation.
        launch(3'd0, 32'd3, 32'd5);
        wait_done(LAT + 10, 0, 5, lat, busy_n);
        chk("flush_no_done", 32'(lat), 32'hFFFF_FFFF);
        chk("flush_busy_cycles", 32'(busy_n), 32'd5);
        chk("flush_result_kept", bus.result, last_res);

        // Flush and start together in IDLE.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.funct3 = 3'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_idle_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;

        // A flush in the DONE cycle does not suppress the done pulse.
        launch(3'd0, 32'd6, 32'd7);
        wait_done(LAT + 10, 0, LAT, lat, busy_n);
        chk("flush_done_latency", 32'(lat), 32'(LAT));
        chk("flush_done_result", bus.result, 32'd42);
        @(negedge clk);
        chk("flush_done_idle", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an operation.
        launch(3'd5, 32'd1000, 32'd10);
        wait_done(19, 0, 0, lat, busy_n);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
        chk("rst_mid_result", bus.result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done(LAT + 10, 0, 0, lat, busy_n);
        chk("rst_no_done", 32'(lat), 32'hFFFF_FFFF);

        // Random regression against the reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 99) < 5) ? 32'd0 : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            exp_v = ref_model(f3, a, b);
            launch(f3, a, b);
            wait_done(LAT + 10, 0, 0, lat, busy_n);
            chk($sformatf("rand%0d_f3_%0d_%h_%h", i, f3, a, b), bus.result, exp_v);
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
